// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search engine and the
// comparator it drives.
package sar_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/sar_search_if.sv
// Handshake between the search engine (master) and whatever starts it and
// supplies the comparator result (slave).
interface sar_search_if #(
  parameter int WIDTH = sar_pkg::WIDTH_DEFAULT
);
  logic             start;
  logic             cmp_gt;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    input  start,
    input  cmp_gt,
    output guess,
    output busy,
    output done,
    output result
  );

  modport slave (
    output start,
    output cmp_gt,
    input  guess,
    input  busy,
    input  done,
    input  result
  );
endinterface

// File: rtl/sar_search.sv
// Binary search over 0..2^WIDTH-1 through a single a > guess comparator bit;
// one compare per cycle, WIDTH compares per search.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  sar_search_if.master bus
);

  localparam int SW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lo, lo_nxt;
  logic [WIDTH-1:0] hi, hi_nxt;
  logic [SW-1:0]    step, step_nxt;
  logic [WIDTH-1:0] result_q, result_nxt;
  logic [WIDTH-1:0] guess_c;

  // Midpoint formed in WIDTH+1 bits so lo+hi cannot wrap.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] l,
                                                input logic [WIDTH-1:0] h);
    logic [WIDTH:0] s;
    s = {1'b0, l} + {1'b0, h};
    return s[WIDTH:1];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lo       <= '0;
      hi       <= '0;
      step     <= '0;
      result_q <= '0;
    end else begin
      state    <= state_nxt;
      lo       <= lo_nxt;
      hi       <= hi_nxt;
      step     <= step_nxt;
      result_q <= result_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    lo_nxt     = lo;
    hi_nxt     = hi;
    step_nxt   = step;
    result_nxt = result_q;
    guess_c    = '0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SEARCH;
          lo_nxt    = '0;
          hi_nxt    = '1;
          step_nxt  = '0;
        end
      end
      SEARCH: begin
        guess_c = midpoint(lo, hi);
        if (bus.cmp_gt) lo_nxt = guess_c + 1'b1;
        else            hi_nxt = guess_c;
        step_nxt = step + 1'b1;
        // The last compare narrows to one value; capture it so result is
        // already valid during the DONE cycle.
        if (step == SW'(WIDTH - 1)) begin
          state_nxt  = DONE;
          result_nxt = lo_nxt;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.guess  = guess_c;
  assign bus.busy   = (state == SEARCH);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: an ideal a > b comparator closes the loop, and the
// expected guess sequence is derived directly from the bits of a.
module tb_sar_search;
  import sar_pkg::*;

  localparam int W = WIDTH_DEFAULT;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a;
  int           vectors = 0;
  int           miscompares = 0;

  sar_search_if #(.WIDTH(W)) sif ();

  sar_search #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.master)
  );

  // Ideal comparator: c = a > b with b = guess.
  assign sif.cmp_gt = (a > sif.guess);

  always #5 clk = ~clk;

  // Compare k of a binary search for a: the top k bits of a are already
  // known, the next bit is tested with guess = known | 0 | all-ones below.
  function automatic logic [W-1:0] exp_guess(input logic [W-1:0] av, input int k);
    int known_mask;
    int low_ones;
    known_mask = ~((1 << (W - k)) - 1);
    low_ones   = (1 << (W - 1 - k)) - 1;
    return W'((int'(av) & known_mask) | low_ones);
  endfunction

  // Runs one search from an IDLE cycle (called at a negedge). hold keeps
  // start high throughout; extra_k pulses start again at that SEARCH cycle.
  task automatic do_search(input logic [W-1:0] av, input bit hold, input int extra_k);
    a         = av;
    sif.start = 1'b1;
    vectors++;
    if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_before a=%0d busy=%b done=%b required busy=0 done=0", av, sif.busy, sif.done);
    end
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      vectors++;
      if (sif.busy !== 1'b1 || sif.done !== 1'b0 || sif.guess !== exp_guess(av, k)) begin
        miscompares++;
        $display("FAIL search a=%0d step=%0d busy=%b done=%b guess=%0d required busy=1 done=0 guess=%0d",
                 av, k, sif.busy, sif.done, sif.guess, exp_guess(av, k));
      end
      if (k == extra_k) sif.start = 1'b1;
      else if (!hold)   sif.start = 1'b0;
    end
    @(negedge clk);
    if (!hold) sif.start = 1'b0;
    vectors++;
    if (sif.done !== 1'b1 || sif.busy !== 1'b0 || sif.result !== av || sif.guess !== '0) begin
      miscompares++;
      $display("FAIL done_cycle a=%0d done=%b busy=%b result=%0d guess=%0d required done=1 busy=0 result=%0d guess=0",
               av, sif.done, sif.busy, sif.result, sif.guess, av);
    end
    @(negedge clk);
    vectors++;
    if (sif.done !== 1'b0 || sif.busy !== 1'b0 || sif.result !== av) begin
      miscompares++;
      $display("FAIL after_done a=%0d done=%b busy=%b result=%0d required done=0 busy=0 result=%0d",
               av, sif.done, sif.busy, sif.result, av);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    sif.start = 1'b1;
    a         = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (sif.guess !== '0 || sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.result !== '0) begin
      miscompares++;
      $display("FAIL reset guess=%0d busy=%b done=%b result=%0d required all 0",
               sif.guess, sif.busy, sif.done, sif.result);
    end
    sif.start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    vectors++;
    if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle busy=%b done=%b required 0 0", sif.busy, sif.done);
    end
  endtask

  task automatic test_directed();
    do_search(W'(0), 1'b0, -1);
    do_search(W'(15), 1'b0, -1);
    do_search(W'(9), 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    for (int v = 0; v < (1 << W); v++) do_search(W'(v), 1'b1, -1);
    sif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_search();
    bit saw_done;
    a         = W'(5);
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (sif.guess !== '0 || sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.result !== '0) begin
      miscompares++;
      $display("FAIL reset_mid guess=%0d busy=%b done=%b result=%0d required all 0",
               sif.guess, sif.busy, sif.done, sif.result);
    end
    saw_done = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (sif.done === 1'b1 || sif.busy === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL reset_abandon activity=1 required 0 after reset");
    end
    do_search(W'(5), 1'b0, -1);
  endtask

  task automatic test_start_during_search();
    do_search(W'(6), 1'b0, 1);
    sif.start = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      vectors++;
      if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
        miscompares++;
        $display("FAIL no_second_search cycle=%0d busy=%b done=%b required 0 0", i, sif.busy, sif.done);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_search(W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)), -1);
    end
    sif.start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    sif.start = 1'b0;
    a         = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_search();
    test_start_during_search();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search engine that drives the operand port of the team's combinational `a > b` magnitude comparator and recovers the unknown value on its other operand. The block presents a guess, reads back the single greater-than bit, and binary-searches the full `WIDTH`-bit range in exactly `WIDTH` compare cycles. It is the initiator for the comparator. It sits beside the comparator in the datapath so that a value seen only through a comparator can be read out as a number.

## Interface
Parameters:
- `WIDTH`, default 4: operand width; search range 0 .. 2^WIDTH-1.

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: reset. One clock; reset is synchronous and active-high.
- `start`, input, 1: begin a search. Sampled only in IDLE.
- `cmp_gt`, input, 1: comparator result `a > guess`. Combinational from `guess` in the same cycle.
- `guess`, output, WIDTH: comparator operand `b`.
- `busy`, output, 1: high while in SEARCH.
- `done`, output, 1: one-cycle pulse when `result` becomes valid.
- `result`, output, WIDTH: recovered value of `a`. Held until the next search completes.

## Operation
- Registers:
  - `lo`, WIDTH bits.
  - `hi`, WIDTH bits.
  - `step` counter, clog2(WIDTH)+1 bits.
  - `result`.
  - state.
- States: IDLE, SEARCH, DONE.
- Transitions:
  - IDLE: `start`=1 → SEARCH. Load `lo`=0, `hi`=2^WIDTH-1, `step`=0.
  - SEARCH: each cycle sample `cmp_gt`.
    - If 1: `lo` ← `guess`+1.
    - If 0: `hi` ← `guess`.
    - `step` increments.
    - When `step`=WIDTH-1 in the current cycle, next state is DONE.
  - DONE: `result` ← `lo`. Next state is IDLE, unconditionally.
- `guess` is the midpoint `(lo+hi)>>1`, computed in WIDTH+1 bits so there is no overflow. It is driven only in SEARCH. In IDLE and DONE, `guess`=0.
- Invariant: `lo` ≤ `hi` always. After WIDTH steps, `lo`==`hi`; at DONE, `result`=`lo`.
- `start` while in SEARCH or DONE is ignored. It is not queued.
- Held `start` in IDLE starts a new search immediately after DONE → IDLE, with one IDLE cycle in between.
- The block assumes `a` is stable for the whole SEARCH phase. A changing `a` yields an unspecified but in-range `result`. No error flag.

## Timing
- Reset values: state=IDLE, `guess`=0, `busy`=0, `done`=0, `result`=0, `lo`=0, `hi`=0, `step`=0.
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..WIDTH: SEARCH. `busy`=1; a new `guess` is presented each cycle.
- Cycle WIDTH+1: DONE. `done`=1, `busy`=0, `result` valid from this cycle on.
- Cycle WIDTH+2: IDLE. `done`=0.
- Start-to-done latency is WIDTH+1 cycles. Minimum start-to-start interval is WIDTH+2 cycles.
- `reset` asserted in any state, including mid-SEARCH: on the next edge, all registers return to reset values. The search is abandoned and `done` is not pulsed. `reset` has priority over `start`.
- `done` is a single-cycle pulse and never stays asserted for two consecutive cycles.

## Structure
- Shared package `sar_pkg` holds:
  - the state enum (IDLE, SEARCH, DONE);
  - the default WIDTH constant (4), shared with the comparator instance.
- The block has no sub-modules: it is a single FSM plus datapath.
- The comparator is instantiated outside, at the enclosing level or in the bench, with `b` ← `guess` and `cmp_gt` ← `c`.

## Test plan
- Case `a`=0, WIDTH=4, pulse `start`:
  - guesses 7, 3, 1, 0 on cycles 1–4;
  - `done` on cycle 5 with `result`=0.
- Case `a`=15:
  - guesses 7, 11, 13, 14;
  - `result`=15 at `done`;
  - `busy` high for exactly 4 cycles.
- Case `a`=9:
  - guesses 7, 11, 9, 8;
  - `result`=9.
- Exhaustive sweep of `a`=0..15, back-to-back with `start` held high:
  - every `result` equals `a`;
  - `done` pulses every 6 cycles.
- Reset during SEARCH: assert `reset` on cycle 2 with `a`=5.
  - Next cycle: IDLE, `guess`=0, `busy`=0, `result`=0.
  - No `done` pulse.
  - A new `start` then yields `result`=5.
- `start` pulsed during SEARCH (`a`=6):
  - ignored;
  - a single `done` with `result`=6 on cycle 5;
  - no second search.
